// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO register store.
// Holds default widths, the stored entry layout and a helper that finds
// the lowest free slot for the default slot count.
package pifo_pkg;

  localparam int REG_WIDTH  = 4;
  localparam int IDX_WIDTH  = 2;
  localparam int DATA_WIDTH = 8;
  localparam int META_WIDTH = 16;
  localparam int CNT_WIDTH  = IDX_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rank;
    logic [META_WIDTH-1:0] meta;
  } entry_t;

  // Lowest-numbered set bit of free_vec; returns 0 when none is set.
  function automatic logic [IDX_WIDTH-1:0] lowest_free(input logic [REG_WIDTH-1:0] free_vec);
    logic [IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = REG_WIDTH - 1; i >= 0; i--) begin
      if (free_vec[i]) idx = IDX_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pifo_free_slot_enc.sv
// Combinational priority encoder selecting the lowest-numbered free slot.
// Ports:
//   free_i  - one bit per slot, 1 = slot is free (i.e. ~valid)
//   found_o - at least one slot is free
//   idx_o   - index of the lowest-numbered free slot (0 when none)
module pifo_free_slot_enc
  import pifo_pkg::*;
#(
  parameter int N  = REG_WIDTH,
  parameter int IW = IDX_WIDTH
) (
  input  logic [N-1:0]  free_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pifo_reg_store.sv
// Storage stage feeding the PIFO min-reduction tree.
// Holds REG_WIDTH (rank, meta) entries with per-slot valid bits and exposes
// all ranks, constant slot indices and valid bits to the tree every cycle.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   ins_valid/rank/meta, ready  - push interface (ready = not full)
//   rm_req, rm_idx              - remove the slot the tree chose
//   rm_valid/rank/meta, rm_err  - removal result one cycle after rm_req
//   tree_data/idx/vld           - flattened per-slot view for the tree
//   count, full, empty          - occupancy status
module pifo_reg_store
  import pifo_pkg::*;
#(
  parameter int REG_W  = REG_WIDTH,
  parameter int IDX_W  = IDX_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int META_W = META_WIDTH,
  parameter int CNT_W  = IDX_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ins_valid,
  input  logic [DATA_W-1:0]       ins_rank,
  input  logic [META_W-1:0]       ins_meta,
  output logic                    ins_ready,
  input  logic                    rm_req,
  input  logic [IDX_W-1:0]        rm_idx,
  output logic                    rm_valid,
  output logic [DATA_W-1:0]       rm_rank,
  output logic [META_W-1:0]       rm_meta,
  output logic                    rm_err,
  output logic [REG_W*DATA_W-1:0] tree_data,
  output logic [REG_W*IDX_W-1:0]  tree_idx,
  output logic [REG_W-1:0]        tree_vld,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REG_W);

  logic [REG_W-1:0]             vld_q, vld_d;
  logic [REG_W-1:0][DATA_W-1:0] rank_q, rank_d;
  logic [REG_W-1:0][META_W-1:0] meta_q, meta_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         rm_valid_q, rm_valid_d;
  logic                         rm_err_q, rm_err_d;
  logic [DATA_W-1:0]            rm_rank_q, rm_rank_d;
  logic [META_W-1:0]            rm_meta_q, rm_meta_d;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             full_q;
  logic             push_fire;
  logic             rm_ok;
  logic             rm_bad;

  pifo_free_slot_enc #(
    .N  (REG_W),
    .IW (IDX_W)
  ) u_free_enc (
    .free_i  (~vld_q),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  assign full_q    = (count_q == CNT_FULL);
  // free_found is redundant with ~full but keeps the push from ever
  // targeting slot 0 by default if the counter and valid bits disagreed.
  assign push_fire = ins_valid & ~full_q & free_found;
  assign rm_ok     = rm_req & vld_q[rm_idx];
  assign rm_bad    = rm_req & ~vld_q[rm_idx];

  always_comb begin
    vld_d      = vld_q;
    rank_d     = rank_q;
    meta_d     = meta_q;
    count_d    = count_q;
    rm_valid_d = rm_ok;
    rm_err_d   = rm_bad;
    rm_rank_d  = rm_rank_q;
    rm_meta_d  = rm_meta_q;

    // Push targets a free slot and remove an occupied one, so both can
    // be applied in the same cycle without interfering.
    if (rm_ok) begin
      vld_d[rm_idx] = 1'b0;
      rm_rank_d     = rank_q[rm_idx];
      rm_meta_d     = meta_q[rm_idx];
    end
    if (push_fire) begin
      vld_d[free_idx]  = 1'b1;
      rank_d[free_idx] = ins_rank;
      meta_d[free_idx] = ins_meta;
    end

    case ({push_fire, rm_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      rank_q     <= '0;
      meta_q     <= '0;
      count_q    <= '0;
      rm_valid_q <= 1'b0;
      rm_err_q   <= 1'b0;
      rm_rank_q  <= '0;
      rm_meta_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      rank_q     <= rank_d;
      meta_q     <= meta_d;
      count_q    <= count_d;
      rm_valid_q <= rm_valid_d;
      rm_err_q   <= rm_err_d;
      rm_rank_q  <= rm_rank_d;
      rm_meta_q  <= rm_meta_d;
    end
  end

  for (genvar g = 0; g < REG_W; g++) begin : g_tree_idx
    assign tree_idx[g*IDX_W +: IDX_W] = IDX_W'(g);
  end

  assign tree_data = rank_q;
  assign tree_vld  = vld_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = (count_q == '0);
  assign ins_ready = ~full_q;
  assign rm_valid  = rm_valid_q;
  assign rm_err    = rm_err_q;
  assign rm_rank   = rm_rank_q;
  assign rm_meta   = rm_meta_q;

endmodule

// File: tb/tb_pifo_reg_store.sv
module tb_pifo_reg_store;

  logic        clk;
  logic        rst;
  logic        ins_valid;
  logic [7:0]  ins_rank;
  logic [15:0] ins_meta;
  logic        ins_ready;
  logic        rm_req;
  logic [1:0]  rm_idx;
  logic        rm_valid;
  logic [7:0]  rm_rank;
  logic [15:0] rm_meta;
  logic        rm_err;
  logic [31:0] tree_data;
  logic [7:0]  tree_idx;
  logic [3:0]  tree_vld;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int total;
  int bad;

  pifo_reg_store dut (
    .clk       (clk),
    .rst       (rst),
    .ins_valid (ins_valid),
    .ins_rank  (ins_rank),
    .ins_meta  (ins_meta),
    .ins_ready (ins_ready),
    .rm_req    (rm_req),
    .rm_idx    (rm_idx),
    .rm_valid  (rm_valid),
    .rm_rank   (rm_rank),
    .rm_meta   (rm_meta),
    .rm_err    (rm_err),
    .tree_data (tree_data),
    .tree_idx  (tree_idx),
    .tree_vld  (tree_vld),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] r, input logic [15:0] m);
    ins_valid = 1'b1;
    ins_rank  = r;
    ins_meta  = m;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    ins_valid = 1'b0;
    ins_rank  = '0;
    ins_meta  = '0;
    rm_req    = 1'b0;
    rm_idx    = '0;
    #12;
    rst = 1'b0;
    #1;

    // reset / idle state
    chk("rst_count",     count,     0);
    chk("rst_empty",     empty,     1);
    chk("rst_full",      full,      0);
    chk("rst_vld",       tree_vld,  4'b0000);
    chk("rst_data",      tree_data, 32'h0);
    chk("rst_idx",       tree_idx,  8'b11_10_01_00);
    chk("rst_ready",     ins_ready, 1);
    chk("rst_rm_valid",  rm_valid,  0);
    chk("rst_rm_err",    rm_err,    0);
    chk("rst_rm_rank",   rm_rank,   0);

    // fill slots 0..3
    push(8'd9, 16'h00A0); step();
    chk("p0_vld",   tree_vld, 4'b0001);
    chk("p0_count", count,    1);
    chk("p0_empty", empty,    0);
    push(8'd4, 16'h00A1); step();
    chk("p1_vld",   tree_vld, 4'b0011);
    push(8'd7, 16'h00A2); step();
    chk("p2_vld",   tree_vld, 4'b0111);
    push(8'd2, 16'h00A3); step();
    chk("p3_vld",   tree_vld,  4'b1111);
    chk("p3_data",  tree_data, 32'h02070409);
    chk("p3_full",  full,      1);
    chk("p3_ready", ins_ready, 0);
    chk("p3_count", count,     4);

    // push while full is dropped
    push(8'd5, 16'h00A5); step();
    chk("drop_count", count,     4);
    chk("drop_data",  tree_data, 32'h02070409);

    // remove slot 3
    ins_valid = 1'b0;
    rm_req = 1'b1; rm_idx = 2'd3; step();
    chk("rm3_valid", rm_valid,  1);
    chk("rm3_rank",  rm_rank,   8'd2);
    chk("rm3_meta",  rm_meta,   16'h00A3);
    chk("rm3_vld",   tree_vld,  4'b0111);
    chk("rm3_ready", ins_ready, 1);
    chk("rm3_count", count,     3);
    chk("rm3_err",   rm_err,    0);

    // simultaneous push rank 6 and remove slot 1
    push(8'd6, 16'h00B6);
    rm_req = 1'b1; rm_idx = 2'd1; step();
    chk("both_valid", rm_valid,  1);
    chk("both_rank",  rm_rank,   8'd4);
    chk("both_meta",  rm_meta,   16'h00A1);
    chk("both_count", count,     3);
    chk("both_vld",   tree_vld,  4'b1101);
    chk("both_slot3", tree_data[31:24], 8'd6);
    chk("both_slot0", tree_data[7:0],   8'd9);

    // remove from empty slot 1
    ins_valid = 1'b0;
    rm_req = 1'b1; rm_idx = 2'd1; step();
    chk("err_err",   rm_err,   1);
    chk("err_valid", rm_valid, 0);
    chk("err_count", count,    3);
    chk("err_vld",   tree_vld, 4'b1101);
    chk("err_rank",  rm_rank,  8'd4);
    chk("err_meta",  rm_meta,  16'h00A1);

    // pulses last one cycle
    rm_req = 1'b0; step();
    chk("idle_err",   rm_err,   0);
    chk("idle_valid", rm_valid, 0);

    // reset while a remove is in flight with 3 entries
    rm_req = 1'b1; rm_idx = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_count", count,    0);
    chk("mrst_vld",   tree_vld, 4'b0000);
    chk("mrst_empty", empty,    1);
    step();
    chk("mrst_rm_valid", rm_valid, 0);
    chk("mrst_rm_err",   rm_err,   0);
    #2;
    rst    = 1'b0;
    rm_req = 1'b0;
    push(8'd3, 16'h00C3); step();
    chk("post_vld",   tree_vld,        4'b0001);
    chk("post_slot0", tree_data[7:0],  8'd3);
    chk("post_count", count,           1);

    // drain to empty, then remove on empty
    ins_valid = 1'b0;
    rm_req = 1'b1; rm_idx = 2'd0; step();
    chk("drain_valid", rm_valid, 1);
    chk("drain_rank",  rm_rank,  8'd3);
    chk("drain_meta",  rm_meta,  16'h00C3);
    chk("drain_empty", empty,    1);
    rm_req = 1'b1; rm_idx = 2'd2; step();
    chk("empty_err",   rm_err,   1);
    chk("empty_valid", rm_valid, 0);
    chk("empty_count", count,    0);
    rm_req = 1'b0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pifo_reg_store.md
Name: pifo_reg_store

Overview:
- Storage stage directly upstream of the PIFO pairwise min-reduction tree.
- Holds REG_WIDTH (rank, metadata) entries with per-slot valid bits.
- Presents all ranks, constant slot indices and valid bits, flattened, to the tree every cycle.
- Accepts pushes and accepts removal of the slot index the tree reports as minimum; returns the removed entry one cycle later.

Parameters:
REG_WIDTH, 4, number of slots; power of two, >= 2
IDX_WIDTH, 2, slot index width; equals log2(REG_WIDTH)
DATA_WIDTH, 8, rank width (unsigned compare key)
META_WIDTH, 16, opaque payload stored with each rank
CNT_WIDTH, 3, occupancy counter width; equals IDX_WIDTH+1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
ins_valid  in  1  push request
ins_rank  in  DATA_WIDTH  rank to push
ins_meta  in  META_WIDTH  payload to push
ins_ready  out  1  push accepted this cycle when high with ins_valid
rm_req  in  1  remove request
rm_idx  in  IDX_WIDTH  slot to remove (winning index from min tree)
rm_valid  out  1  one-cycle pulse; removed entry on rm_rank/rm_meta
rm_rank  out  DATA_WIDTH  removed rank
rm_meta  out  META_WIDTH  removed payload
rm_err  out  1  one-cycle pulse; remove targeted an empty slot
tree_data  out  REG_WIDTH*DATA_WIDTH  slot i rank at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
tree_idx  out  REG_WIDTH*IDX_WIDTH  slot i carries constant value i
tree_vld  out  REG_WIDTH  bit i = slot i valid
count  out  CNT_WIDTH  occupied slots
full  out  1  count == REG_WIDTH
empty  out  1  count == 0

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - All valid bits 0 and count 0, so full=0 and empty=1.
  - rm_valid=0, rm_err=0, rm_rank=0, rm_meta=0.
  - Rank/meta storage is also cleared to 0.
  - tree_data therefore reads 0 and tree_vld reads 0.
- tree_data, tree_vld and count/full/empty come directly from registers; no combinational path from any input.
- tree_idx is a constant.
- ins_ready = ~full. It depends on registered state only and does not consider a concurrent remove.
- Push fires when ins_valid & ins_ready:
  - Target slot = lowest-numbered slot with valid=0 (priority encoder on ~valid).
  - On the next edge that slot gets rank and meta, and its valid bit becomes 1.
- Remove fires when rm_req=1:
  - If valid[rm_idx]=1: on the next edge valid[rm_idx] clears; rm_rank/rm_meta take the slot contents; rm_valid=1 for one cycle. Latency is 1 cycle from request to data.
  - If valid[rm_idx]=0: no state change; rm_err=1 for one cycle; rm_valid=0; rm_rank/rm_meta hold their previous values.
- Simultaneous push and remove: both execute in the same cycle. The push target is a free slot and the remove target is an occupied slot, so they never collide. count is unchanged.
- count update, using the fired push and the successful remove:
  - push only: count+1
  - remove only: count-1
  - both, or neither: unchanged
  - A failed remove does not decrement count.
- Full: ins_ready=0 and pushes are dropped (the producer must hold). A remove in that cycle still proceeds, and ins_ready rises the following cycle.
- Empty: any rm_req produces rm_err. tree_vld=0 lets the downstream tree report invalid.
- Ranks may repeat. Tie ordering is decided downstream; this block does not track arrival order.
- A reset asserted mid-operation discards all entries immediately. Any in-flight rm_valid pulse is suppressed.

Decomposition:
- Shared package pifo_pkg:
  - Default widths REG_WIDTH, IDX_WIDTH, DATA_WIDTH, META_WIDTH.
  - Entry struct typedef {rank, meta}.
  - A function returning the lowest free slot index.
- One natural sub-module: pifo_free_slot_enc, a combinational priority encoder with inputs ~valid and outputs {found, idx}.
- The remainder (storage, counter, remove path) stays in the top.

Test Plan:
- Reset then idle: count=0, empty=1, tree_vld=4'b0000, tree_idx={2'd3,2'd2,2'd1,2'd0}, ins_ready=1.
- Push ranks 9,4,7,2 (meta 0xA0..0xA3) on consecutive cycles: slots 0..3 filled, tree_data={8'd2,8'd7,8'd4,8'd9}, full=1, ins_ready=0.
- Push rank 5 while full: dropped, count stays 4. Then rm_req with rm_idx=3: next cycle rm_valid=1, rm_rank=2, rm_meta=0xA3, tree_vld=4'b0111, ins_ready=1.
- Same cycle push rank 6 and rm_req idx=1 (count=3, slot 3 free): slot 3 becomes rank 6, slot 1 cleared, rm_rank=4, count stays 3, tree_vld=4'b1101.
- rm_req idx=1 on the empty slot: rm_err=1 for one cycle, rm_valid=0, count unchanged, storage unchanged.
- Assert rst while rm_req is in flight with 3 entries: rm_valid stays 0, count=0, tree_vld=0 immediately. After release, a push lands in slot 0.
